// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback scheduler.
package regfile_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // Writeback requester identity; also the encoding of the arbiter's last grant.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with combinational grant and a last-grant flop.
// Request/grant bit 0 is the ALU, bit 1 the LSU.
module rr_arbiter2
    import regfile_wb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    wb_src_e last_grant_q;
    wb_src_e last_grant_d;

    // Grant selection; history only advances when both requesters contended.
    always_comb begin
        gnt_o        = req_i;
        last_grant_d = last_grant_q;
        if (req_i == 2'b11) begin
            if (last_grant_q == WB_ALU) begin
                gnt_o        = 2'b10;
                last_grant_d = WB_LSU;
            end else begin
                gnt_o        = 2'b01;
                last_grant_d = WB_ALU;
            end
        end
    end

    // Last-grant register; resets to ALU so the first contention goes to the LSU.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= WB_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks onto the
// single write port and keeps a busy scoreboard that stalls RAW/WAW hazards.
// Optional build macro REGFILE_WB_BYPASS_EN lets a source matching the
// register being written this cycle issue and take its value from rf_wd3_o.
module regfile_wb_scheduler
    import regfile_wb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] issue_rs1_i,
    input  logic [ADDRESS_WIDTH-1:0] issue_rs2_i,
    input  logic                     issue_rs1_used_i,
    input  logic                     issue_rs2_used_i,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd_i,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    input  logic                     lsu_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd_i,
    input  logic [ADDRESS_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0]    alu_data_i,
    input  logic [DATA_WIDTH-1:0]    lsu_data_i,
    output logic                     alu_ready_o,
    output logic                     lsu_ready_o,
    output logic [ADDRESS_WIDTH-1:0] rf_a3_o,
    output logic [DATA_WIDTH-1:0]    rf_wd3_o,
    output logic                     rf_we3_o,
    output logic                     fwd1_sel_o,
    output logic                     fwd2_sel_o,
    output logic [(2**ADDRESS_WIDTH)-1:0] busy_o,
    output logic                     err_o
);

    localparam int unsigned NREGS = 2 ** ADDRESS_WIDTH;

    logic [NREGS-1:0]         busy_q, busy_d;
    logic                     err_q, err_d;
    logic                     flushed_q, flushed_d;

    logic [1:0]               gnt_c;
    logic                     alu_gnt_c, lsu_gnt_c;
    logic [ADDRESS_WIDTH-1:0] wb_rd_c;
    logic [DATA_WIDTH-1:0]    wb_data_c;
    logic                     wb_we_c;
    logic                     byp1_c, byp2_c;
    logic                     hazard_c;
    logic                     fire_c;

    rr_arbiter2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  ({lsu_valid_i, alu_valid_i}),
        .gnt_o  (gnt_c)
    );

    // Grants are suppressed while reset is asserted.
    assign alu_gnt_c = gnt_c[0] & rst_ni;
    assign lsu_gnt_c = gnt_c[1] & rst_ni;

    // Write-port mux; idle port drives zeros.
    always_comb begin
        wb_rd_c   = '0;
        wb_data_c = '0;
        if (alu_gnt_c) begin
            wb_rd_c   = alu_rd_i;
            wb_data_c = alu_data_i;
        end else if (lsu_gnt_c) begin
            wb_rd_c   = lsu_rd_i;
            wb_data_c = lsu_data_i;
        end
    end

    assign wb_we_c = (alu_gnt_c | lsu_gnt_c) && (wb_rd_c != '0);

`ifdef REGFILE_WB_BYPASS_EN
    // A source matching the register written this cycle reads the write data.
    assign byp1_c = wb_we_c && (issue_rs1_i == wb_rd_c);
    assign byp2_c = wb_we_c && (issue_rs2_i == wb_rd_c);
`else
    assign byp1_c = 1'b0;
    assign byp2_c = 1'b0;
`endif

    // RAW on used sources (minus bypass) and WAW on the destination, from flop state.
    assign hazard_c = (issue_rs1_used_i & busy_q[issue_rs1_i] & ~byp1_c)
                    | (issue_rs2_used_i & busy_q[issue_rs2_i] & ~byp2_c)
                    | busy_q[issue_rd_i];

    assign fire_c = issue_valid_i & issue_ready_o & ~flush_i;

    // Scoreboard and sticky-error next state; a set overrides a same-edge clear.
    always_comb begin
        busy_d    = busy_q;
        err_d     = err_q;
        flushed_d = flushed_q | flush_i;
        if (wb_we_c) begin
            if (!busy_q[wb_rd_c] && !flushed_q) begin
                err_d = 1'b1;
            end
            busy_d[wb_rd_c] = 1'b0;
        end
        if (flush_i) begin
            busy_d = '0;
        end else if (fire_c && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard, error and flush-seen registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            err_q     <= err_d;
            flushed_q <= flushed_d;
        end
    end

    assign issue_ready_o = rst_ni & ~hazard_c;
    assign alu_ready_o   = alu_gnt_c;
    assign lsu_ready_o   = lsu_gnt_c;
    assign rf_a3_o       = wb_rd_c;
    assign rf_wd3_o      = wb_data_c;
    assign rf_we3_o      = wb_we_c;
    assign fwd1_sel_o    = byp1_c & issue_rs1_used_i;
    assign fwd2_sel_o    = byp2_c & issue_rs2_used_i;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler (default parameters).
module tb_regfile_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic        issue_rs1_used_i, issue_rs2_used_i;
    logic        flush_i;
    logic        alu_valid_i, lsu_valid_i;
    logic [4:0]  alu_rd_i, lsu_rd_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        alu_ready_o, lsu_ready_o;
    logic [4:0]  rf_a3_o;
    logic [31:0] rf_wd3_o;
    logic        rf_we3_o;
    logic        fwd1_sel_o, fwd2_sel_o;
    logic [31:0] busy_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    regfile_wb_scheduler dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_rs1_i      (issue_rs1_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_rs1_used_i (issue_rs1_used_i),
        .issue_rs2_used_i (issue_rs2_used_i),
        .issue_rd_i       (issue_rd_i),
        .flush_i          (flush_i),
        .alu_valid_i      (alu_valid_i),
        .lsu_valid_i      (lsu_valid_i),
        .alu_rd_i         (alu_rd_i),
        .lsu_rd_i         (lsu_rd_i),
        .alu_data_i       (alu_data_i),
        .lsu_data_i       (lsu_data_i),
        .alu_ready_o      (alu_ready_o),
        .lsu_ready_o      (lsu_ready_o),
        .rf_a3_o          (rf_a3_o),
        .rf_wd3_o         (rf_wd3_o),
        .rf_we3_o         (rf_we3_o),
        .fwd1_sel_o       (fwd1_sel_o),
        .fwd2_sel_o       (fwd2_sel_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i    = 1'b0;
        issue_rs1_i      = 5'd0;
        issue_rs2_i      = 5'd0;
        issue_rs1_used_i = 1'b0;
        issue_rs2_used_i = 1'b0;
        issue_rd_i       = 5'd0;
        flush_i          = 1'b0;
        alu_valid_i      = 1'b0;
        lsu_valid_i      = 1'b0;
        alu_rd_i         = 5'd0;
        lsu_rd_i         = 5'd0;
        alu_data_i       = 32'd0;
        lsu_data_i       = 32'd0;
    endtask

    // Advance one edge; inputs may change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
    endtask

    initial begin
        idle_inputs();
        rst_ni      = 1'b0;
        // Requests during reset must not be granted or written.
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd1;
        issue_valid_i = 1'b1;
        #3;
        chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
        chk("rst_alu_ready",   64'(alu_ready_o),   64'd0);
        chk("rst_we",          64'(rf_we3_o),      64'd0);
        tick();
        idle_inputs();
        tick();
        rst_ni = 1'b1;
        #1;

        // Idle after reset.
        chk("idle_busy",  64'(busy_o),        64'd0);
        chk("idle_ready", 64'(issue_ready_o), 64'd1);
        chk("idle_we",    64'(rf_we3_o),      64'd0);
        chk("idle_err",   64'(err_o),         64'd0);

        // Issue rd=5.
        issue(5'd5);
        #1 chk("iss5_ready", 64'(issue_ready_o), 64'd1);
        tick();
        chk("iss5_busy", 64'(busy_o), 64'h20);

        // RAW on rs1=5 stalls.
        issue_rd_i       = 5'd0;
        issue_rs1_i      = 5'd5;
        issue_rs1_used_i = 1'b1;
        #1 chk("raw_stall", 64'(issue_ready_o), 64'd0);
        tick();
        chk("raw_busy_hold", 64'(busy_o), 64'h20);

        // ALU writes rd=5 while the dependent instruction waits.
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd5;
        alu_data_i  = 32'hDEADBEEF;
        #1;
        chk("wb5_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("wb5_we",        64'(rf_we3_o),    64'd1);
        chk("wb5_a3",        64'(rf_a3_o),     64'd5);
        chk("wb5_wd3",       64'(rf_wd3_o),    64'hDEADBEEF);
`ifdef REGFILE_WB_BYPASS_EN
        chk("wb5_ready_byp", 64'(issue_ready_o), 64'd1);
        chk("wb5_fwd1",      64'(fwd1_sel_o),    64'd1);
`else
        chk("wb5_ready",     64'(issue_ready_o), 64'd0);
        chk("wb5_fwd1",      64'(fwd1_sel_o),    64'd0);
`endif
        tick();
        alu_valid_i = 1'b0;
        #1;
        chk("post5_ready", 64'(issue_ready_o), 64'd1);
        chk("post5_busy",  64'(busy_o),        64'd0);
        chk("post5_err",   64'(err_o),         64'd0);
        idle_inputs();

        // Mark rd=3 and rd=4 busy.
        issue(5'd3);
        tick();
        issue(5'd4);
        tick();
        idle_inputs();
        chk("b34_busy", 64'(busy_o), 64'h18);

        // Contention: ALU rd=3, LSU rd=4 for three cycles -> LSU, ALU, LSU.
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'hAAAA0003;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_data_i = 32'hBBBB0004;
        #1;
        chk("rr1_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("rr1_alu_ready", 64'(alu_ready_o), 64'd0);
        chk("rr1_a3",        64'(rf_a3_o),     64'd4);
        chk("rr1_wd3",       64'(rf_wd3_o),    64'hBBBB0004);
        tick();
        chk("rr1_busy", 64'(busy_o), 64'h08);
        // Re-issue rd=4 so the third LSU write targets a busy register.
        issue(5'd4);
        #1;
        chk("rr2_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("rr2_lsu_ready", 64'(lsu_ready_o), 64'd0);
        chk("rr2_a3",        64'(rf_a3_o),     64'd3);
        chk("rr2_wd3",       64'(rf_wd3_o),    64'hAAAA0003);
        tick();
        issue_valid_i = 1'b0;
        chk("rr2_busy", 64'(busy_o), 64'h10);
        #1;
        chk("rr3_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("rr3_a3",        64'(rf_a3_o),     64'd4);
        chk("rr3_wd3",       64'(rf_wd3_o),    64'hBBBB0004);
        tick();
        idle_inputs();
        chk("rr3_busy", 64'(busy_o), 64'd0);
        chk("rr3_err",  64'(err_o),  64'd0);

        // Write to r0: granted but not written, no error.
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h1;
        #1;
        chk("r0_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("r0_we",        64'(rf_we3_o),    64'd0);
        tick();
        idle_inputs();
        chk("r0_err", 64'(err_o), 64'd0);

        // Stale write to non-busy rd=6 before any flush sets the sticky error.
        alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_data_i = 32'h66;
        tick();
        idle_inputs();
        tick();
        chk("stale_err", 64'(err_o), 64'd1);

        // Reset clears error and flush history.
        rst_ni = 1'b0;
        #1;
        chk("rst2_err",   64'(err_o),  64'd0);
        chk("rst2_busy",  64'(busy_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Busy {2,9}, then flush while an issue is presented.
        issue(5'd2);
        tick();
        issue(5'd9);
        tick();
        chk("b29_busy", 64'(busy_o), 64'h204);
        issue(5'd11);
        flush_i = 1'b1;
        tick();
        idle_inputs();
        chk("flush_busy", 64'(busy_o), 64'd0);

        // Post-flush stale write is legal.
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
        #1;
        chk("pf_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("pf_we",        64'(rf_we3_o),    64'd1);
        tick();
        idle_inputs();
        chk("pf_err", 64'(err_o), 64'd0);

        // Same edge: issue rd=7 sets while LSU clears rd=7; set wins.
        issue(5'd7);
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h77;
        #1 chk("se_ready", 64'(issue_ready_o), 64'd1);
        tick();
        idle_inputs();
        chk("se_busy", 64'(busy_o), 64'h80);
        chk("se_err",  64'(err_o),  64'd0);

        // WAW: rd=7 now busy, issue stalls.
        issue(5'd7);
        #1 chk("waw_stall", 64'(issue_ready_o), 64'd0);
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
